// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared heading/state encodings for the snake motion controller
// Contents:
//   heading_t   : WEST=0, EAST=1, NORTH=2, SOUTH=3 (bit 1 selects the axis)
//   state_t     : IDLE, RUN, PAUSE, HALT
//   is_reverse  : true when two headings point in opposite directions on one axis
package snake_pkg;

  typedef enum logic [1:0] {
    WEST  = 2'd0,
    EAST  = 2'd1,
    NORTH = 2'd2,
    SOUTH = 2'd3
  } heading_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    HALT  = 2'd3
  } state_t;

  // Same axis bit, different direction bit means a 180 degree turn.
  function automatic logic is_reverse(heading_t a, heading_t b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// rtl/snake_tick_gen.sv - movement interval counter with period compare
// Ports:
//   Clock, Reset : clock, asynchronous active-high reset
//   run          : counter advances only while high, otherwise holds its value
//   period       : clocks per step
//   tick         : combinational; high in the cycle whose closing edge is the step edge
module snake_tick_gen #(
  parameter int TICK_W = 28
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              run,
  input  logic [TICK_W-1:0] period,
  output logic              tick
);

  logic [TICK_W-1:0] count;

  assign tick = run && (count == period - TICK_W'(1));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else if (run) begin
      count <= count + TICK_W'(1);
    end
  end

endmodule

// File: rtl/snake_motion_ctrl.sv
// rtl/snake_motion_ctrl.sv - snake head motion controller (tick, turn buffer, stepping, lock)
// Ports:
//   Clock, Reset                  : clock, asynchronous active-high reset
//   iEnable                       : run/pause
//   iGameOver                     : game-over flag, locks controls after GO_DLY clocks
//   iWest/iEast/iNorth/iSouth     : direction requests (South > North > East > West)
//   iSnakeLength                  : body length, selects step period
//   oSnakeLocationX/Y             : head position
//   oHeading                      : current heading (heading_t encoding)
//   oIconTick                     : one-cycle pulse when position changed
//   oWallHit                      : sticky, wall reached (WRAP=0)
//   oCtrlOff                      : sticky, controls locked
module snake_motion_ctrl
  import snake_pkg::*;
#(
  parameter int COORD_W     = 11,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int START_X     = 240,
  parameter int START_Y     = 380,
  parameter int TICK_W      = 28,
  parameter int PERIOD_SLOW = 10_000_000,
  parameter int PERIOD_MID  = 6_000_000,
  parameter int PERIOD_FAST = 2_000_000,
  parameter int LEN_W       = 8,
  parameter int LEN_MID     = 20,
  parameter int LEN_FAST    = 50,
  parameter int WRAP        = 0,
  parameter int GO_DLY      = 2
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iEnable,
  input  logic               iGameOver,
  input  logic               iWest,
  input  logic               iEast,
  input  logic               iNorth,
  input  logic               iSouth,
  input  logic [LEN_W-1:0]   iSnakeLength,
  output logic [COORD_W-1:0] oSnakeLocationX,
  output logic [COORD_W-1:0] oSnakeLocationY,
  output logic [1:0]         oHeading,
  output logic               oIconTick,
  output logic               oWallHit,
  output logic               oCtrlOff
);

  localparam int GO_W = (GO_DLY < 1) ? 1 : $clog2(GO_DLY + 1);

  function automatic logic [TICK_W-1:0] periodFor(logic [LEN_W-1:0] len);
    if (len >= LEN_W'(LEN_FAST))     return TICK_W'(PERIOD_FAST);
    else if (len >= LEN_W'(LEN_MID)) return TICK_W'(PERIOD_MID);
    else                             return TICK_W'(PERIOD_SLOW);
  endfunction

  state_t             state, stateNext;
  heading_t           heading, pending, request;
  logic               reqValid, accept;
  logic [TICK_W-1:0]  period;
  logic               run, tick;
  logic [COORD_W-1:0] nextX, nextY;
  logic               outOfBounds;
  logic [GO_W-1:0]    goCnt, goCntNext;

  assign oHeading = heading;

  // The lock stops the counter at once so no step sneaks in before HALT.
  assign run = (state == RUN) && !oCtrlOff;

  snake_tick_gen #(.TICK_W(TICK_W)) u_tick (
    .Clock  (Clock),
    .Reset  (Reset),
    .run    (run),
    .period (period),
    .tick   (tick)
  );

  always_comb begin
    reqValid = 1'b1;
    request  = WEST;
    if (iSouth)      request = SOUTH;
    else if (iNorth) request = NORTH;
    else if (iEast)  request = EAST;
    else if (iWest)  request = WEST;
    else             reqValid = 1'b0;
  end

  assign accept = reqValid && !oCtrlOff && (state != HALT) &&
                  !is_reverse(request, heading) && (request != heading);

  // Next position uses pending, which becomes the heading on the step edge.
  always_comb begin
    nextX       = oSnakeLocationX;
    nextY       = oSnakeLocationY;
    outOfBounds = 1'b0;
    case (pending)
      WEST: begin
        if (oSnakeLocationX == '0) begin
          if (WRAP != 0) nextX = COORD_W'(X_MAX);
          else           outOfBounds = 1'b1;
        end else nextX = oSnakeLocationX - COORD_W'(1);
      end
      EAST: begin
        if (oSnakeLocationX == COORD_W'(X_MAX)) begin
          if (WRAP != 0) nextX = '0;
          else           outOfBounds = 1'b1;
        end else nextX = oSnakeLocationX + COORD_W'(1);
      end
      NORTH: begin
        if (oSnakeLocationY == '0) begin
          if (WRAP != 0) nextY = COORD_W'(Y_MAX);
          else           outOfBounds = 1'b1;
        end else nextY = oSnakeLocationY - COORD_W'(1);
      end
      default: begin
        if (oSnakeLocationY == COORD_W'(Y_MAX)) begin
          if (WRAP != 0) nextY = '0;
          else           outOfBounds = 1'b1;
        end else nextY = oSnakeLocationY + COORD_W'(1);
      end
    endcase
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (iEnable) stateNext = RUN;
      RUN: begin
        if (oCtrlOff || (tick && outOfBounds)) stateNext = HALT;
        else if (!iEnable)                     stateNext = PAUSE;
      end
      PAUSE:   if (iEnable) stateNext = RUN;
      default: stateNext = HALT;
    endcase
  end

  always_comb begin
    if (!iGameOver)                 goCntNext = '0;
    else if (goCnt == GO_W'(GO_DLY)) goCntNext = goCnt;
    else                            goCntNext = goCnt + GO_W'(1);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      oSnakeLocationX <= COORD_W'(START_X);
      oSnakeLocationY <= COORD_W'(START_Y);
      heading         <= EAST;
      pending         <= EAST;
      period          <= TICK_W'(PERIOD_SLOW);
      oIconTick       <= 1'b0;
      oWallHit        <= 1'b0;
      oCtrlOff        <= 1'b0;
      goCnt           <= '0;
    end else begin
      oIconTick <= 1'b0;
      goCnt     <= goCntNext;
      if (goCntNext == GO_W'(GO_DLY)) oCtrlOff <= 1'b1;
      // Presses on the step edge itself are dropped so pending == heading after a step.
      if (tick) begin
        heading <= pending;
        period  <= periodFor(iSnakeLength);
        if (outOfBounds) begin
          oWallHit <= 1'b1;
        end else begin
          oSnakeLocationX <= nextX;
          oSnakeLocationY <= nextY;
          oIconTick       <= 1'b1;
        end
      end else if (accept) begin
        pending <= request;
      end
    end
  end

endmodule

// File: tb/tb_snake_motion_ctrl.sv
// tb/tb_snake_motion_ctrl.sv - directed self-checking bench for snake_motion_ctrl
module tb_snake_motion_ctrl;
  import snake_pkg::*;

  logic        Clock, Reset, iEnable, iGameOver, iWest, iEast, iNorth, iSouth;
  logic [7:0]  iSnakeLength;
  logic [10:0] x0, y0, x1, y1;
  logic [1:0]  hd0, hd1;
  logic        tk0, wh0, co0, tk1, wh1, co1;
  int          tests, fails;

  snake_motion_ctrl #(
    .X_MAX(15), .Y_MAX(15), .START_X(2), .START_Y(2),
    .PERIOD_SLOW(4), .PERIOD_MID(3), .PERIOD_FAST(2), .WRAP(0), .GO_DLY(2)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iEnable(iEnable), .iGameOver(iGameOver),
    .iWest(iWest), .iEast(iEast), .iNorth(iNorth), .iSouth(iSouth),
    .iSnakeLength(iSnakeLength), .oSnakeLocationX(x0), .oSnakeLocationY(y0),
    .oHeading(hd0), .oIconTick(tk0), .oWallHit(wh0), .oCtrlOff(co0)
  );

  snake_motion_ctrl #(
    .X_MAX(15), .Y_MAX(15), .START_X(2), .START_Y(2),
    .PERIOD_SLOW(4), .PERIOD_MID(3), .PERIOD_FAST(2), .WRAP(1), .GO_DLY(2)
  ) dutw (
    .Clock(Clock), .Reset(Reset), .iEnable(iEnable), .iGameOver(iGameOver),
    .iWest(iWest), .iEast(iEast), .iNorth(iNorth), .iSouth(iSouth),
    .iSnakeLength(iSnakeLength), .oSnakeLocationX(x1), .oSnakeLocationY(y1),
    .oHeading(hd1), .oIconTick(tk1), .oWallHit(wh1), .oCtrlOff(co1)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic clk();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      clk();
      n++;
    end while (!tk0 && n < 40);
  endtask

  task automatic press(input logic w, input logic e, input logic n, input logic s);
    iWest = w; iEast = e; iNorth = n; iSouth = s;
    clk();
    iWest = 0; iEast = 0; iNorth = 0; iSouth = 0;
  endtask

  task automatic start_run(input logic [7:0] len);
    Reset = 1; iEnable = 0; iGameOver = 0; iSnakeLength = len;
    iWest = 0; iEast = 0; iNorth = 0; iSouth = 0;
    clk();
    Reset = 0;
    iEnable = 1;
  endtask

  task automatic test_reset();
    Reset = 1; iEnable = 0; iGameOver = 0; iSnakeLength = 5;
    iWest = 0; iEast = 0; iNorth = 0; iSouth = 0;
    #1;
    tests++;
    if (x0 !== 11'd2 || y0 !== 11'd2 || hd0 !== 2'd1) begin
      fails++; $display("FAIL reset_pos: got (%0d,%0d,h%0d) want (2,2,h1)", x0, y0, hd0);
    end
    tests++;
    if ({tk0, wh0, co0} !== 3'b000 || dut.state !== IDLE) begin
      fails++; $display("FAIL reset_flags: got tk%0b wh%0b co%0b st%0d want 0 0 0 st0", tk0, wh0, co0, dut.state);
    end
  endtask

  task automatic test_basic();
    int n;
    start_run(8'd5);
    for (int i = 0; i < 3; i++) begin
      wait_tick(n);
      tests++;
      if (n !== ((i == 0) ? 5 : 4)) begin
        fails++; $display("FAIL basic_interval%0d: got %0d want %0d", i, n, (i == 0) ? 5 : 4);
      end
      tests++;
      if (x0 !== 11'(3 + i) || y0 !== 11'd2 || hd0 !== 2'd1) begin
        fails++; $display("FAIL basic_pos%0d: got (%0d,%0d,h%0d) want (%0d,2,h1)", i, x0, y0, hd0, 3 + i);
      end
    end
    clk();
    tests++;
    if (tk0 !== 1'b0) begin
      fails++; $display("FAIL basic_pulse_width: got %0b want 0", tk0);
    end
  endtask

  task automatic test_turns();
    int n;
    start_run(8'd5);
    wait_tick(n);
    press(1, 0, 0, 0);
    press(0, 0, 1, 0);
    wait_tick(n);
    tests++;
    if (hd0 !== 2'd2 || x0 !== 11'd3 || y0 !== 11'd1) begin
      fails++; $display("FAIL turn_north: got (%0d,%0d,h%0d) want (3,1,h2)", x0, y0, hd0);
    end
    press(0, 0, 0, 1);
    wait_tick(n);
    tests++;
    if (hd0 !== 2'd2 || x0 !== 11'd3 || y0 !== 11'd0) begin
      fails++; $display("FAIL turn_reverse_drop: got (%0d,%0d,h%0d) want (3,0,h2)", x0, y0, hd0);
    end
    press(0, 1, 0, 0);
    wait_tick(n);
    tests++;
    if (hd0 !== 2'd1 || x0 !== 11'd4 || y0 !== 11'd0) begin
      fails++; $display("FAIL turn_east: got (%0d,%0d,h%0d) want (4,0,h1)", x0, y0, hd0);
    end
    start_run(8'd5);
    wait_tick(n);
    press(1, 0, 0, 0);
    wait_tick(n);
    tests++;
    if (hd0 !== 2'd1 || x0 !== 11'd4 || y0 !== 11'd2) begin
      fails++; $display("FAIL west_drop: got (%0d,%0d,h%0d) want (4,2,h1)", x0, y0, hd0);
    end
    press(0, 0, 1, 1);
    wait_tick(n);
    tests++;
    if (hd0 !== 2'd3 || x0 !== 11'd4 || y0 !== 11'd3) begin
      fails++; $display("FAIL priority_south: got (%0d,%0d,h%0d) want (4,3,h3)", x0, y0, hd0);
    end
  endtask

  task automatic test_period();
    int n;
    start_run(8'd5);
    wait_tick(n);
    wait_tick(n);
    clk(); clk();
    iSnakeLength = 8'd20;
    wait_tick(n);
    tests++;
    if (n !== 2) begin
      fails++; $display("FAIL period_current_kept: got %0d want 2", n);
    end
    for (int i = 0; i < 2; i++) begin
      wait_tick(n);
      tests++;
      if (n !== 3) begin
        fails++; $display("FAIL period_mid%0d: got %0d want 3", i, n);
      end
    end
    clk();
    iSnakeLength = 8'd50;
    wait_tick(n);
    tests++;
    if (n !== 2) begin
      fails++; $display("FAIL period_mid_kept: got %0d want 2", n);
    end
    for (int i = 0; i < 2; i++) begin
      wait_tick(n);
      tests++;
      if (n !== 2) begin
        fails++; $display("FAIL period_fast%0d: got %0d want 2", i, n);
      end
    end
  endtask

  task automatic test_wall();
    int n;
    logic seen;
    start_run(8'd5);
    for (int i = 0; i < 13; i++) wait_tick(n);
    tests++;
    if (x0 !== 11'd15 || x1 !== 11'd15) begin
      fails++; $display("FAIL wall_reach: got x0=%0d x1=%0d want 15 15", x0, x1);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      clk();
      if (tk0) seen = 1;
    end
    tests++;
    if (seen !== 1'b0 || x0 !== 11'd15 || wh0 !== 1'b1 || dut.state !== HALT) begin
      fails++; $display("FAIL wall_halt: got tick%0b x%0d wh%0b st%0d want 0 15 1 st3", seen, x0, wh0, dut.state);
    end
    tests++;
    if (x1 !== 11'd0 || tk1 !== 1'b1 || wh1 !== 1'b0) begin
      fails++; $display("FAIL wrap_east: got x%0d tick%0b wh%0b want 0 1 0", x1, tk1, wh1);
    end
    for (int i = 0; i < 8; i++) clk();
    tests++;
    if (x0 !== 11'd15 || wh0 !== 1'b1) begin
      fails++; $display("FAIL wall_frozen: got x%0d wh%0b want 15 1", x0, wh0);
    end
    Reset = 1;
    #1;
    tests++;
    if (wh0 !== 1'b0 || x0 !== 11'd2) begin
      fails++; $display("FAIL wall_reset: got wh%0b x%0d want 0 2", wh0, x0);
    end
  endtask

  task automatic test_gameover();
    int n;
    logic seen;
    start_run(8'd5);
    wait_tick(n);
    iGameOver = 1; clk();
    iGameOver = 0; clk();
    tests++;
    if (co0 !== 1'b0) begin
      fails++; $display("FAIL go_short: got %0b want 0", co0);
    end
    wait_tick(n);
    iGameOver = 1; clk(); clk();
    iGameOver = 0;
    tests++;
    if (co0 !== 1'b1) begin
      fails++; $display("FAIL go_lock: got %0b want 1", co0);
    end
    press(0, 0, 1, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      clk();
      if (tk0) seen = 1;
    end
    tests++;
    if (seen !== 1'b0 || x0 !== 11'd4 || y0 !== 11'd2 || hd0 !== 2'd1 || co0 !== 1'b1) begin
      fails++; $display("FAIL go_frozen: got tick%0b (%0d,%0d,h%0d) co%0b want 0 (4,2,h1) 1", seen, x0, y0, hd0, co0);
    end
    Reset = 1;
    #1;
    tests++;
    if (co0 !== 1'b0) begin
      fails++; $display("FAIL go_reset: got %0b want 0", co0);
    end
  endtask

  task automatic test_pause_reset();
    int n;
    logic seen;
    start_run(8'd5);
    wait_tick(n);
    clk();
    iEnable = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      clk();
      if (tk0) seen = 1;
    end
    tests++;
    if (seen !== 1'b0 || x0 !== 11'd3) begin
      fails++; $display("FAIL pause_frozen: got tick%0b x%0d want 0 3", seen, x0);
    end
    iEnable = 1;
    wait_tick(n);
    tests++;
    if (n !== 3 || x0 !== 11'd4) begin
      fails++; $display("FAIL pause_resume: got n%0d x%0d want 3 4", n, x0);
    end
    press(0, 0, 0, 1);
    wait_tick(n);
    #2;
    Reset = 1;
    #1;
    tests++;
    if (x0 !== 11'd2 || y0 !== 11'd2 || hd0 !== 2'd1 || {tk0, wh0, co0} !== 3'b000) begin
      fails++; $display("FAIL async_reset: got (%0d,%0d,h%0d) flags %b want (2,2,h1) 000", x0, y0, hd0, {tk0, wh0, co0});
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_turns();
    test_period();
    test_wall();
    test_gameover();
    test_pause_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/snake_motion_ctrl.md
Name: snake_motion_ctrl

Overview:
Parametrised snake-head motion controller for the VGA snake game. It generates the movement tick internally and buffers direction presses with reversal rejection. It steps the head position one cell per tick, with speed chosen from snake length, and supports either wall-halt or wrap-around playfield edges. It sits between the debounced button inputs and the body/collision/render logic, and runs entirely in the Clock domain with no derived clocks.

Parameters:
COORD_W, 11, width of X/Y coordinates
X_MAX, 639, largest legal X
Y_MAX, 479, largest legal Y
START_X, 240, X after reset
START_Y, 380, Y after reset
TICK_W, 28, width of the tick counter
PERIOD_SLOW, 10_000_000, clocks per step when length < LEN_MID
PERIOD_MID, 6_000_000, clocks per step when LEN_MID <= length < LEN_FAST
PERIOD_FAST, 2_000_000, clocks per step when length >= LEN_FAST
LEN_W, 8, width of the length input
LEN_MID, 20, first speed-up threshold
LEN_FAST, 50, second speed-up threshold
WRAP, 0, edge mode: 0 = halt at wall, 1 = wrap to the opposite edge
GO_DLY, 2, consecutive iGameOver clocks before controls lock

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-high reset
iEnable  in  1  run/pause; movement only while high
iGameOver  in  1  game-over flag from collision logic
iWest  in  1  direction request
iEast  in  1  direction request
iNorth  in  1  direction request
iSouth  in  1  direction request
iSnakeLength  in  LEN_W  current body length
oSnakeLocationX  out  COORD_W  head X
oSnakeLocationY  out  COORD_W  head Y
oHeading  out  2  current heading (package encoding)
oIconTick  out  1  one-cycle pulse; position just changed
oWallHit  out  1  sticky flag; wall reached (WRAP=0 only)
oCtrlOff  out  1  controls locked after game over

Behaviour:
- Reset values: X=START_X, Y=START_Y, heading=EAST, pending=EAST, counter=0, state=IDLE, oIconTick=0, oWallHit=0, oCtrlOff=0, period=PERIOD_SLOW.
- FSM states:
  - IDLE: counter held at 0. Go to RUN when iEnable=1.
  - RUN: counter runs. Go to PAUSE when iEnable=0. Go to HALT when oCtrlOff=1 or a wall is hit.
  - PAUSE: counter and position frozen. Return to RUN when iEnable=1, keeping the counter value.
  - HALT: everything frozen. Left only by Reset.
- Tick:
  - In RUN, the counter counts 0..period-1.
  - On the edge where counter==period-1: counter goes to 0, the step is applied, and oIconTick goes high for exactly one cycle.
  - The new X/Y is visible in the same cycle as oIconTick=1.
- Period:
  - Selected from iSnakeLength and latched only at the step edge.
  - A length change therefore affects the next interval, never the current one.
- Direction buffer:
  - Each clock in which oCtrlOff=0 and the state is not HALT, a press is evaluated.
  - Priority when several are high: South > North > East > West.
  - The request is accepted into pending only if it lies on the axis perpendicular to heading. Same-axis requests, including 180° reversals, are dropped.
  - Every accepted press overwrites pending.
  - At the step edge, heading takes pending, then the move uses the new heading.
  - At most one turn per step; after a step, pending equals heading.
- Step arithmetic:
  - W: X-1. E: X+1. N: Y-1. S: Y+1. Computed at COORD_W width.
  - WRAP=1: X at 0 moving W becomes X_MAX; X at X_MAX moving E becomes 0. Y wraps the same way with Y_MAX.
  - WRAP=0: a step that would leave [0,X_MAX]×[0,Y_MAX] leaves the position unchanged, sets oWallHit=1, moves the FSM to HALT, and produces no oIconTick.
- Control lock:
  - A saturating counter increments while iGameOver=1 and clears when iGameOver=0.
  - oCtrlOff=1 once the count reaches GO_DLY.
  - oCtrlOff stays 1 until Reset even if iGameOver later drops.
- Simultaneous events: if oCtrlOff rises in the same cycle as a step edge, the step still completes and HALT is entered on the next cycle.
- Reset mid-step: asynchronous; all outputs return to their reset values immediately, and any in-flight tick is discarded.

Decomposition:
- Shared package snake_pkg holds:
  - heading encoding: WEST=2'd0, EAST=2'd1, NORTH=2'd2, SOUTH=2'd3
  - FSM state enum: IDLE, RUN, PAUSE, HALT
  - helper constant function is_reverse(a,b)
- Sub-module snake_tick_gen, with ports: Clock, Reset, run, period, tick. It contains the counter and the period compare.

Test Plan:
- Bench parameters for all scenarios: PERIOD_SLOW=4, PERIOD_MID=3, PERIOD_FAST=2, X_MAX=15, Y_MAX=15, START=(2,2), GO_DLY=2.
- Reset, then iEnable=1, length=5: oIconTick pulses every 4 clocks; X goes 3, 4, 5; Y stays 2; oHeading=EAST.
- Heading EAST, pulse iWest then iNorth in one interval: at the next tick oHeading=NORTH and Y=1. Pulse iWest alone instead: the request is dropped and X increments.
- Length changed from 5 to 20 mid-interval: the current interval stays 4 clocks and the following intervals are 3 clocks; length 50 gives 2-clock intervals.
- WRAP=0, start at X=14 heading EAST: one tick to X=15, next step edge leaves X=15, sets oWallHit=1, no oIconTick, FSM in HALT. WRAP=1: X goes 15 then 0.
- iGameOver held 1 clock then 0: oCtrlOff stays 0. Held 2 clocks: oCtrlOff=1, positions freeze, and direction presses are ignored until Reset.
- iEnable dropped for 10 clocks mid-interval: no tick occurs and the counter resumes from its held value. Reset asserted mid-interval: outputs are immediately (2,2), EAST, all flags 0.
